// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared register-file constants and the write-request payload used by the write-port arbiter.
package regfile_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned ENTRY_W  = ADDR_W + DATA_W;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Pipeline/MUL-DIV/register-file bundle for the write-port arbiter; master is the pipeline side.
interface regfile_wport_if;
   import regfile_pkg::*;

   logic              WbWrite;
   logic [ADDR_W-1:0] WbAddr;
   logic [DATA_W-1:0] WbData;
   logic              MdIssue;
   logic [ADDR_W-1:0] MdIssueAddr;
   logic              MdValid;
   logic              MdReady;
   logic [ADDR_W-1:0] MdAddr;
   logic [DATA_W-1:0] MdData;
   logic [ADDR_W-1:0] IdRsAddr;
   logic [ADDR_W-1:0] IdRtAddr;
   logic [ADDR_W-1:0] IdRdAddr;
   logic              Hazard;
   logic              StallReq;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteAddr;
   logic [DATA_W-1:0] WriteData;

   modport master (
      output WbWrite, WbAddr, WbData, MdIssue, MdIssueAddr, MdValid, MdAddr, MdData,
             IdRsAddr, IdRtAddr, IdRdAddr,
      input  MdReady, Hazard, StallReq, RegWrite, WriteAddr, WriteData
   );

   modport slave (
      input  WbWrite, WbAddr, WbData, MdIssue, MdIssueAddr, MdValid, MdAddr, MdData,
             IdRsAddr, IdRtAddr, IdRdAddr,
      output MdReady, Hazard, StallReq, RegWrite, WriteAddr, WriteData
   );

endinterface

// File: rtl/regfile_wport_arbiter_md_result_fifo.sv
// Small power-of-two FIFO holding MUL/DIV results ({addr, data}) until a free write slot.
module md_result_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = ENTRY_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full_c,
   output logic         empty_c,
   output logic [W-1:0] head_c
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push_c, do_pop_c;

   assign full_c  = (cnt_q == CNT_W'(DEPTH));
   assign empty_c = (cnt_q == '0);
   assign head_c  = mem_q[rd_ptr_q];

   // A push into a full queue is only taken when the head leaves in the same cycle.
   assign do_pop_c  = pop && !empty_c;
   assign do_push_c = push && (!full_c || do_pop_c);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      if (do_push_c) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between WB (priority) and queued MUL/DIV results.
// Optional MD_BYPASS_EN: an MD result meeting an empty queue and idle WB is written in the same cycle.
module regfile_wport_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic            clk,
   input logic            rst_n,
   regfile_wport_if.slave bus
);

   localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

   logic                wb_busy_c;
   logic                full_c, empty_c;
   logic [ENTRY_W-1:0]  head_c;
   logic                push_c, pop_c, byp_c;
   wr_req_t             wr_sel_c;

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [SCNT_W-1:0]   scnt_q, scnt_d;
   logic                stall_q, stall_d;

   // A WB write to r0 is dropped and leaves the slot free for the queue.
   assign wb_busy_c = bus.WbWrite && (bus.WbAddr != ADDR_W'(REG_ZERO));

   md_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_c),
      .din     ({bus.MdAddr, bus.MdData}),
      .pop     (pop_c),
      .full_c  (full_c),
      .empty_c (empty_c),
      .head_c  (head_c)
   );

   // Write-port select: WB, then queue head, then (optionally) the live MD result.
   always_comb begin
      wr_sel_c = '0;
      pop_c    = 1'b0;
      byp_c    = 1'b0;
      if (wb_busy_c) begin
         wr_sel_c.valid = 1'b1;
         wr_sel_c.addr  = bus.WbAddr;
         wr_sel_c.data  = bus.WbData;
      end else if (!empty_c) begin
         wr_sel_c.valid                  = 1'b1;
         {wr_sel_c.addr, wr_sel_c.data}  = head_c;
         pop_c                           = 1'b1;
      end
`ifdef MD_BYPASS_EN
      else if (bus.MdValid) begin
         wr_sel_c.valid = 1'b1;
         wr_sel_c.addr  = bus.MdAddr;
         wr_sel_c.data  = bus.MdData;
         byp_c          = 1'b1;
      end
`endif
   end

   assign push_c        = bus.MdValid && !full_c && !byp_c;
   assign bus.MdReady   = !full_c;
   assign bus.RegWrite  = rst_n && wr_sel_c.valid;
   assign bus.WriteAddr = wr_sel_c.addr;
   assign bus.WriteData = wr_sel_c.data;
   assign bus.StallReq  = stall_q;
   assign bus.Hazard    = pending_q[bus.IdRsAddr] | pending_q[bus.IdRtAddr] | pending_q[bus.IdRdAddr];

   // Pending scoreboard: an MD write clears its bit, a same-cycle issue re-sets it.
   always_comb begin
      pending_d = pending_q;
      if (pop_c || byp_c) begin
         pending_d[wr_sel_c.addr] = 1'b0;
      end
      if (bus.MdIssue && (bus.MdIssueAddr != ADDR_W'(REG_ZERO))) begin
         pending_d[bus.MdIssueAddr] = 1'b1;
      end
      pending_d[REG_ZERO] = 1'b0;
   end

   // Starvation: a waiting queue that cannot pop is blocked by WB; after the limit, ask for a bubble.
   always_comb begin
      scnt_d  = scnt_q;
      stall_d = 1'b0;
      if (pop_c || empty_c) begin
         scnt_d = '0;
      end else if (scnt_q == SCNT_W'(STARVE_LIMIT - 1)) begin
         scnt_d  = '0;
         stall_d = 1'b1;
      end else begin
         scnt_d = scnt_q + SCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         scnt_q    <= '0;
         stall_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         scnt_q    <= scnt_d;
         stall_q   <= stall_d;
      end
   end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized scoreboard bench for regfile_wport_arbiter (honours MD_BYPASS_EN when defined).
module tb_regfile_wport_arbiter;
   import regfile_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   regfile_wport_if bus();

   regfile_wport_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } exp_t;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } res_t;

   // Reference model state: expected write stream, MD queue contents, pending set, starvation.
   exp_t        exp_q[$];
   res_t        mq[$];
   logic [31:0] pend;
   int          starve;
   bit          stall_exp;
   bit          bubble;
   bit          last_taken;

   // Producer / issue model for the random phases.
   int          iss_q[$];
   bit          md_hold;
   int          md_a;
   logic [31:0] md_d;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t mon_e;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
   endtask

   task automatic drive(input bit wbw, input int wba, input logic [31:0] wbd,
                        input bit iss, input int issa,
                        input bit mdv, input int mda, input logic [31:0] mdd);
      bus.WbWrite     = wbw;
      bus.WbAddr      = ADDR_W'(wba);
      bus.WbData      = wbd;
      bus.MdIssue     = iss;
      bus.MdIssueAddr = ADDR_W'(issa);
      bus.MdValid     = mdv;
      bus.MdAddr      = ADDR_W'(mda);
      bus.MdData      = mdd;
   endtask

   task automatic id(input int rs, input int rt, input int rd);
      bus.IdRsAddr = ADDR_W'(rs);
      bus.IdRtAddr = ADDR_W'(rt);
      bus.IdRdAddr = ADDR_W'(rd);
   endtask

   task automatic model_reset();
      exp_q.delete();
      mq.delete();
      iss_q.delete();
      pend      = '0;
      starve    = 0;
      stall_exp = 1'b0;
      bubble    = 1'b0;
      md_hold   = 1'b0;
   endtask

   // One clock cycle: inputs are already driven (posedge+1); returns at the next posedge+1.
   task automatic step();
      bit          wb_busy, full, pop, byp, acc, st;
      exp_t        e;
      res_t        h;
      logic [31:0] pn;
      int          sn;
      wb_busy = bus.WbWrite && (bus.WbAddr != 0);
      full    = (mq.size() == DEPTH);
      pop     = 1'b0;
      byp     = 1'b0;
      e       = '0;
      if (wb_busy) e = {1'b1, bus.WbAddr, bus.WbData};
      else if (mq.size() > 0) begin
         e   = {1'b1, mq[0].a, mq[0].d};
         pop = 1'b1;
      end
`ifdef MD_BYPASS_EN
      else if (bus.MdValid) begin
         e   = {1'b1, bus.MdAddr, bus.MdData};
         byp = 1'b1;
      end
`endif
      acc = bus.MdValid && !full && !byp;
      exp_q.push_back(e);

      @(negedge clk);
      chk("md_ready", bus.MdReady, !full);
      chk("hazard", bus.Hazard, pend[bus.IdRsAddr] | pend[bus.IdRtAddr] | pend[bus.IdRdAddr]);
      chk("stall_req", bus.StallReq, stall_exp);

      pn = pend;
      if (pop || byp) pn[e.a] = 1'b0;
      if (bus.MdIssue && bus.MdIssueAddr != 0) pn[bus.MdIssueAddr] = 1'b1;
      pn[0] = 1'b0;
      st = 1'b0;
      if (pop || mq.size() == 0) sn = 0;
      else begin
         sn = starve + 1;
         if (sn >= int'(LIMIT)) begin
            sn = 0;
            st = 1'b1;
         end
      end
      h = {bus.MdAddr, bus.MdData};

      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(h);
      pend       = pn;
      starve     = sn;
      bubble     = stall_exp;
      stall_exp  = st;
      last_taken = acc || byp;
      #1;
   endtask

   // Monitor: every cycle out of reset the DUT's write port is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("reg_write", bus.RegWrite, mon_e.we);
               if (mon_e.we && bus.RegWrite) begin
                  chk("write_addr", bus.WriteAddr, mon_e.a);
                  chk("write_data", bus.WriteData, mon_e.d);
               end
            end else begin
               chk("idle_write", bus.RegWrite, 1'b0);
            end
         end
      end
   end

   task automatic run_random(input int cycles, input int wb_pct, input int iss_pct, input int md_pct);
      bit          wbw, iss;
      int          wba, issa, a;
      for (int c = 0; c < cycles; c++) begin
         if (!md_hold && iss_q.size() > 0 && $urandom_range(99) < md_pct) begin
            md_a    = iss_q.pop_front();
            md_d    = $urandom;
            md_hold = 1'b1;
         end
         wbw  = !bubble && ($urandom_range(99) < wb_pct);
         wba  = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 31));
         iss  = 1'b0;
         issa = 0;
         if ($urandom_range(99) < iss_pct) begin
            a = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 31));
            if (a == 0 || !pend[a]) begin
               iss  = 1'b1;
               issa = a;
               if (a != 0) iss_q.push_back(a);
            end
         end
         drive(wbw, wba, $urandom, iss, issa, md_hold, md_a, md_d);
         id($urandom_range(31), $urandom_range(31), $urandom_range(31));
         step();
         if (md_hold && last_taken) md_hold = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      model_reset();
      // Reset state with a busy WB request already present.
      drive(1, 5, 32'h5555_5555, 0, 0, 0, 0, 0);
      id(0, 0, 0);
      #12;
      chk("rst_regwrite", bus.RegWrite, 1'b0);
      chk("rst_md_ready", bus.MdReady, 1'b1);
      chk("rst_hazard", bus.Hazard, 1'b0);
      chk("rst_stall", bus.StallReq, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Two results queue behind WB traffic with r8/r9 pending.
      id(8, 9, 0);
      drive(1, 3, 32'h33, 1, 8, 0, 0, 0);           step();
      drive(1, 3, 32'h34, 1, 9, 0, 0, 0);           step();
      drive(1, 3, 32'h35, 0, 0, 1, 8, 32'hA8);      step();
      drive(1, 3, 32'h36, 0, 0, 1, 9, 32'hA9);      step();
      drive(1, 3, 32'h37, 0, 0, 0, 0, 0);
      exp_q.delete();
      rst_n = 1'b0;
      #2;
      chk("midrst_regwrite", bus.RegWrite, 1'b0);
      chk("midrst_md_ready", bus.MdReady, 1'b1);
      chk("midrst_hazard", bus.Hazard, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // Idle WB: result latency and hazard release.
      id(8, 0, 0);
      drive(0, 0, 0, 1, 8, 0, 0, 0);                step();
      drive(0, 0, 0, 0, 0, 1, 8, 32'hDEAD_BEEF);    step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);                step();
      step();
      // WB busy to r3 while an r9 result arrives, then WB to r0 with the queue non-empty.
      id(9, 0, 0);
      drive(0, 0, 0, 1, 9, 0, 0, 0);                step();
      drive(1, 3, 32'h1234, 0, 0, 1, 9, 32'h99);    step();
      drive(1, 3, 32'h5678, 0, 0, 0, 0, 0);         step();
      drive(1, 0, 32'hBAD0, 0, 0, 0, 0, 0);         step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);                step();
      // Issue to r0 never raises a hazard.
      id(0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0);                step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);                step();

      run_random(150, 40, 30, 60);
      run_random(120, 100, 40, 90);
      run_random(150, 80, 50, 70);
      run_random(100, 10, 40, 50);

      for (int i = 0; i < 80 && (mq.size() > 0 || md_hold || iss_q.size() > 0); i++) begin
         run_random(1, 0, 0, 100);
      end
      chk("drain_done", 64'(mq.size() + iss_q.size() + int'(md_hold)), 64'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      @(negedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
